// File: rtl/cpu_pkg.sv
// cpu_pkg: operand select codes, micro-op classes and ALU op constants shared across the datapath
package cpu_pkg;
  localparam logic [2:0] SEL_A    = 3'd0;
  localparam logic [2:0] SEL_F    = 3'd1;
  localparam logic [2:0] SEL_M    = 3'd2;
  localparam logic [2:0] SEL_SP   = 3'd3;
  localparam logic [2:0] SEL_X    = 3'd4;
  localparam logic [2:0] SEL_Y    = 3'd5;
  localparam logic [2:0] SEL_ZERO = 3'd6;
  localparam logic [3:0] ALU_PASS = 4'h0;
  localparam logic [3:0] ALU_INC  = 4'h8;
  localparam logic [3:0] ALU_DEC  = 4'h9;
  typedef enum logic [2:0] {
    CLS_XFER, CLS_ARITH, CLS_CMP, CLS_RMW, CLS_PUSH, CLS_PULL, CLS_NOP6, CLS_NOP7
  } cls_e;
endpackage

// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: decoder request handshake plus datapath control strobes
interface alu_sequencer_if #(parameter int OP_W = 4, parameter int SEL_W = 3);
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_class;
  logic [SEL_W-1:0] req_src;
  logic [SEL_W-1:0] req_dst;
  logic [OP_W-1:0]  req_op;
  logic             mem_ack;
  logic [SEL_W-1:0] alu_a_sel;
  logic             alu_b_mem;
  logic [OP_W-1:0]  alu_op;
  logic             reg_we;
  logic [SEL_W-1:0] reg_wsel;
  logic             flag_we;
  logic             mdr_we;
  logic             mem_rd;
  logic             mem_wr;
  logic             done;
  modport master (
    output req_valid, req_class, req_src, req_dst, req_op, mem_ack,
    input  req_ready, alu_a_sel, alu_b_mem, alu_op, reg_we, reg_wsel, flag_we, mdr_we, mem_rd, mem_wr, done
  );
  modport slave (
    input  req_valid, req_class, req_src, req_dst, req_op, mem_ack,
    output req_ready, alu_a_sel, alu_b_mem, alu_op, reg_we, reg_wsel, flag_we, mdr_we, mem_rd, mem_wr, done
  );
endinterface

// File: rtl/alu_seq_decode.sv
// alu_seq_decode: combinational datapath control decode from sequencer phase and latched micro-op
module alu_seq_decode
  import cpu_pkg::*;
#(
  parameter int OP_W  = 4,
  parameter int SEL_W = 3
) (
  input  logic             st_read_i,
  input  logic             st_exec_i,
  input  logic             st_write_i,
  input  logic             st_data_i,
  input  logic             st_spadj_i,
  input  logic             st_load_i,
  input  logic             st_nops_i,
  input  cls_e             cls_i,
  input  logic [SEL_W-1:0] src_i,
  input  logic [SEL_W-1:0] dst_i,
  input  logic [OP_W-1:0]  op_i,
  input  logic             mem_ack_i,
  output logic [SEL_W-1:0] alu_a_sel_o,
  output logic             alu_b_mem_o,
  output logic [OP_W-1:0]  alu_op_o,
  output logic             reg_we_o,
  output logic [SEL_W-1:0] reg_wsel_o,
  output logic             flag_we_o,
  output logic             mdr_we_o,
  output logic             mem_rd_o,
  output logic             mem_wr_o,
  output logic             done_o
);
  // idle values first, then each phase overrides only the controls it owns
  always_comb begin
    alu_a_sel_o = SEL_ZERO;
    alu_b_mem_o = 1'b0;
    alu_op_o    = ALU_PASS;
    reg_we_o    = 1'b0;
    reg_wsel_o  = SEL_A;
    flag_we_o   = 1'b0;
    mdr_we_o    = 1'b0;
    mem_rd_o    = st_read_i;
    mem_wr_o    = st_write_i | st_data_i;
    done_o      = 1'b0;
    if (st_exec_i) begin
      alu_a_sel_o = (cls_i == CLS_ARITH) ? SEL_A : (cls_i == CLS_RMW) ? SEL_M : src_i;
      alu_b_mem_o = (cls_i == CLS_ARITH) || (cls_i == CLS_CMP);
      alu_op_o    = (cls_i == CLS_XFER) ? ALU_PASS : op_i;
      reg_we_o    = (cls_i == CLS_XFER) || (cls_i == CLS_ARITH);
      reg_wsel_o  = (cls_i == CLS_XFER) ? dst_i : SEL_A;
      flag_we_o   = (cls_i != CLS_XFER) || (dst_i != SEL_SP);
      mdr_we_o    = cls_i == CLS_RMW;
      done_o      = cls_i != CLS_RMW;
    end
    if (st_write_i) done_o = mem_ack_i;
    if (st_data_i) begin
      alu_a_sel_o = src_i;
      mdr_we_o    = 1'b1;
    end
    if (st_spadj_i) begin
      alu_a_sel_o = SEL_SP;
      alu_op_o    = (cls_i == CLS_PUSH) ? ALU_DEC : ALU_INC;
      reg_we_o    = 1'b1;
      reg_wsel_o  = SEL_SP;
      done_o      = cls_i == CLS_PUSH;
    end
    if (st_load_i) begin
      alu_a_sel_o = SEL_M;
      reg_we_o    = 1'b1;
      reg_wsel_o  = dst_i;
      flag_we_o   = dst_i inside {SEL_A, SEL_X, SEL_Y};
      done_o      = 1'b1;
    end
    if (st_nops_i) done_o = 1'b1;
  end
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: issues one ALU micro-op class at a time, stalling memory phases on mem_ack
module alu_sequencer
  import cpu_pkg::*;
#(
  parameter int OP_W  = 4,
  parameter int SEL_W = 3
) (
  input logic            clk,
  input logic            rst,
  alu_sequencer_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_READ, S_EXEC, S_WRITE, S_DATA, S_SPADJ, S_LOAD, S_NOPS} state_e;
  state_e           state_q, state_d;
  cls_e             cls_q;
  logic [SEL_W-1:0] src_q, dst_q;
  logic [OP_W-1:0]  op_q;
  logic             accept;
  assign bus.req_ready = state_q == S_IDLE;
  assign accept        = bus.req_valid && bus.req_ready;
  // state register; reset aborts any micro-op in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end
  // request fields are held for the whole micro-op
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cls_q <= CLS_XFER;
      src_q <= '0;
      dst_q <= '0;
      op_q  <= '0;
    end else if (accept) begin
      cls_q <= cls_e'(bus.req_class);
      src_q <= bus.req_src;
      dst_q <= bus.req_dst;
      op_q  <= bus.req_op;
    end
  end
  // next state: the first action phase is entered on the accepting edge
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept)
                 state_d = (bus.req_class == CLS_XFER) ? S_EXEC :
                           (bus.req_class inside {CLS_ARITH, CLS_CMP, CLS_RMW}) ? S_READ :
                           (bus.req_class == CLS_PUSH) ? S_DATA :
                           (bus.req_class == CLS_PULL) ? S_SPADJ : S_NOPS;
      S_READ:  if (bus.mem_ack) state_d = (cls_q == CLS_PULL) ? S_LOAD : S_EXEC;
      S_EXEC:  state_d = (cls_q == CLS_RMW) ? S_WRITE : S_IDLE;
      S_WRITE: if (bus.mem_ack) state_d = S_IDLE;
      S_DATA:  if (bus.mem_ack) state_d = S_SPADJ;
      S_SPADJ: state_d = (cls_q == CLS_PULL) ? S_READ : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  alu_seq_decode #(.OP_W(OP_W), .SEL_W(SEL_W)) u_decode (
    .st_read_i   (state_q == S_READ),
    .st_exec_i   (state_q == S_EXEC),
    .st_write_i  (state_q == S_WRITE),
    .st_data_i   (state_q == S_DATA),
    .st_spadj_i  (state_q == S_SPADJ),
    .st_load_i   (state_q == S_LOAD),
    .st_nops_i   (state_q == S_NOPS),
    .cls_i       (cls_q),
    .src_i       (src_q),
    .dst_i       (dst_q),
    .op_i        (op_q),
    .mem_ack_i   (bus.mem_ack),
    .alu_a_sel_o (bus.alu_a_sel),
    .alu_b_mem_o (bus.alu_b_mem),
    .alu_op_o    (bus.alu_op),
    .reg_we_o    (bus.reg_we),
    .reg_wsel_o  (bus.reg_wsel),
    .flag_we_o   (bus.flag_we),
    .mdr_we_o    (bus.mdr_we),
    .mem_rd_o    (bus.mem_rd),
    .mem_wr_o    (bus.mem_wr),
    .done_o      (bus.done)
  );
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: table vectors, corner sequences and random micro-ops against a step-list model
module tb_alu_sequencer;
  typedef struct packed {
    logic [2:0] a_sel;
    logic       b_mem;
    logic [3:0] op;
    logic       reg_we;
    logic [2:0] wsel;
    logic       flag_we;
    logic       mdr_we;
    logic       mem_rd;
    logic       mem_wr;
    logic       done;
  } out_t;
  typedef struct {
    out_t o;
    bit   stall;
  } step_t;
  typedef struct {
    logic [2:0] c, s, d;
    logic [3:0] op;
    int         lat;
    out_t       o;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  step_t exp_q[$];
  vec_t  tv[10];
  alu_sequencer_if #(.OP_W(4), .SEL_W(3)) bus ();
  alu_sequencer #(.OP_W(4), .SEL_W(3)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  function automatic out_t mk(input logic [2:0] a, input logic b, input logic [3:0] op, input logic we,
                              input logic [2:0] ws, input logic fl, input logic mdr, input logic rd,
                              input logic wr, input logic dn);
    out_t o;
    o = '{a_sel: a, b_mem: b, op: op, reg_we: we, wsel: ws, flag_we: fl, mdr_we: mdr, mem_rd: rd, mem_wr: wr, done: dn};
    return o;
  endfunction

  function automatic out_t idle_o();
    return mk(3'd6, 0, 4'h0, 0, 3'd0, 0, 0, 0, 0, 0);
  endfunction

  function automatic out_t dut_o();
    return mk(bus.alu_a_sel, bus.alu_b_mem, bus.alu_op, bus.reg_we, bus.reg_wsel, bus.flag_we,
              bus.mdr_we, bus.mem_rd, bus.mem_wr, bus.done);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input out_t o, input bit stall);
    step_t st;
    st.o = o;
    st.stall = stall;
    exp_q.push_back(st);
  endtask

  // the micro-op as a list of cycles; a stall step repeats until mem_ack
  task automatic build(input logic [2:0] c, input logic [2:0] s, input logic [2:0] d, input logic [3:0] op);
    out_t rd;
    exp_q.delete();
    rd = idle_o();
    rd.mem_rd = 1;
    case (c)
      3'd0: push(mk(s, 0, 4'h0, 1, d, d != 3'd3, 0, 0, 0, 1), 0);
      3'd1: begin push(rd, 1); push(mk(3'd0, 1, op, 1, 3'd0, 1, 0, 0, 0, 1), 0); end
      3'd2: begin push(rd, 1); push(mk(s, 1, op, 0, 3'd0, 1, 0, 0, 0, 1), 0); end
      3'd3: begin
        push(rd, 1);
        push(mk(3'd2, 0, op, 0, 3'd0, 1, 1, 0, 0, 0), 0);
        push(mk(3'd6, 0, 4'h0, 0, 3'd0, 0, 0, 0, 1, 1), 1);
      end
      3'd4: begin
        push(mk(s, 0, 4'h0, 0, 3'd0, 0, 1, 0, 1, 0), 1);
        push(mk(3'd3, 0, 4'h9, 1, 3'd3, 0, 0, 0, 0, 1), 0);
      end
      3'd5: begin
        push(mk(3'd3, 0, 4'h8, 1, 3'd3, 0, 0, 0, 0, 0), 0);
        push(rd, 1);
        push(mk(3'd2, 0, 4'h0, 1, d, d == 3'd0 || d == 3'd4 || d == 3'd5, 0, 0, 0, 1), 0);
      end
      default: push(mk(3'd6, 0, 4'h0, 0, 3'd0, 0, 0, 0, 0, 1), 0);
    endcase
  endtask

  // issue one request and check every cycle; fw<0 picks random stall lengths
  task automatic run_req(input logic [2:0] c, input logic [2:0] s, input logic [2:0] d, input logic [3:0] op, input int fw);
    out_t e;
    int nw;
    build(c, s, d, op);
    @(negedge clk);
    bus.req_valid = 1;
    bus.req_class = c;
    bus.req_src = s;
    bus.req_dst = d;
    bus.req_op = op;
    bus.mem_ack = 1'($urandom);
    #1;
    chk("idle_ready", 32'(bus.req_ready), 32'd1);
    chk("idle_out", 32'(dut_o()), 32'(idle_o()));
    for (int i = 0; i < exp_q.size(); i++) begin
      nw = exp_q[i].stall ? (fw >= 0 ? fw : int'($urandom_range(0, 2))) : 0;
      for (int w = 0; w <= nw; w++) begin
        @(negedge clk);
        bus.req_valid = (i == exp_q.size() - 1) ? 1'b0 : 1'($urandom);
        bus.req_class = 3'($urandom);
        bus.req_src = 3'($urandom);
        bus.req_dst = 3'($urandom);
        bus.req_op = 4'($urandom);
        bus.mem_ack = exp_q[i].stall ? (w == nw) : 1'($urandom);
        #1;
        e = exp_q[i].o;
        if (exp_q[i].stall) e.done = e.done & bus.mem_ack;
        chk($sformatf("cls%0d_step%0d", c, i), 32'(dut_o()), 32'(e));
        chk("busy_ready", 32'(bus.req_ready), 32'd0);
      end
    end
  endtask

  initial begin
    int lat;
    out_t got;
    bus.req_valid = 0;
    bus.req_class = 0;
    bus.req_src = 0;
    bus.req_dst = 0;
    bus.req_op = 0;
    bus.mem_ack = 1;
    tv[0] = '{3'd0, 3'd4, 3'd3, 4'h5, 1, mk(3'd4, 0, 4'h0, 1, 3'd3, 0, 0, 0, 0, 1)};
    tv[1] = '{3'd0, 3'd5, 3'd0, 4'h2, 1, mk(3'd5, 0, 4'h0, 1, 3'd0, 1, 0, 0, 0, 1)};
    tv[2] = '{3'd1, 3'd2, 3'd4, 4'h1, 2, mk(3'd0, 1, 4'h1, 1, 3'd0, 1, 0, 0, 0, 1)};
    tv[3] = '{3'd2, 3'd4, 3'd1, 4'h3, 2, mk(3'd4, 1, 4'h3, 0, 3'd0, 1, 0, 0, 0, 1)};
    tv[4] = '{3'd3, 3'd1, 3'd2, 4'h8, 3, mk(3'd6, 0, 4'h0, 0, 3'd0, 0, 0, 0, 1, 1)};
    tv[5] = '{3'd4, 3'd0, 3'd5, 4'h7, 2, mk(3'd3, 0, 4'h9, 1, 3'd3, 0, 0, 0, 0, 1)};
    tv[6] = '{3'd5, 3'd2, 3'd1, 4'h4, 3, mk(3'd2, 0, 4'h0, 1, 3'd1, 0, 0, 0, 0, 1)};
    tv[7] = '{3'd5, 3'd0, 3'd4, 4'h4, 3, mk(3'd2, 0, 4'h0, 1, 3'd4, 1, 0, 0, 0, 1)};
    tv[8] = '{3'd6, 3'd3, 3'd3, 4'hf, 1, mk(3'd6, 0, 4'h0, 0, 3'd0, 0, 0, 0, 0, 1)};
    tv[9] = '{3'd7, 3'd1, 3'd2, 4'ha, 1, mk(3'd6, 0, 4'h0, 0, 3'd0, 0, 0, 0, 0, 1)};
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out", 32'(dut_o()), 32'(idle_o()));
    chk("reset_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    rst = 0;
    #1;
    chk("idle_out_after_reset", 32'(dut_o()), 32'(idle_o()));
    foreach (tv[i]) begin
      @(negedge clk);
      bus.req_valid = 1;
      bus.req_class = tv[i].c;
      bus.req_src = tv[i].s;
      bus.req_dst = tv[i].d;
      bus.req_op = tv[i].op;
      bus.mem_ack = 1;
      lat = 0;
      got = '0;
      @(posedge clk);
      for (int k = 1; k <= 8; k++) begin
        @(negedge clk);
        bus.req_valid = 0;
        #1;
        if (bus.done) begin
          lat = k;
          got = dut_o();
          break;
        end
      end
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(tv[i].lat));
      chk($sformatf("vec%0d_done_out", i), 32'(got), 32'(tv[i].o));
    end
    run_req(3'd0, 3'd4, 3'd3, 4'h5, -1);
    run_req(3'd1, 3'd6, 3'd2, 4'h1, 3);
    run_req(3'd3, 3'd1, 3'd1, 4'h8, 0);
    run_req(3'd4, 3'd0, 3'd7, 4'h0, 0);
    run_req(3'd5, 3'd2, 3'd1, 4'h0, 0);
    run_req(3'd7, 3'd0, 3'd0, 4'h0, -1);
    for (int n = 0; n < 80; n++)
      run_req(3'($urandom), 3'($urandom_range(0, 6)), 3'($urandom_range(0, 6)), 4'($urandom), -1);
    @(negedge clk);
    bus.req_valid = 1;
    bus.req_class = 3'd3;
    bus.req_op = 4'h8;
    bus.mem_ack = 1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    bus.mem_ack = 0;
    #1;
    chk("rmw_write_strobe", 32'(bus.mem_wr), 32'd1);
    #1 rst = 1;
    #1;
    chk("rst_drops_wr", 32'(bus.mem_wr), 32'd0);
    chk("rst_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    rst = 0;
    bus.mem_ack = 1;
    #1;
    chk("post_rst_idle", 32'(dut_o()), 32'(idle_o()));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
